// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
// Optional feature macro: MEM_RESPONDER_RR_EN (round-robin arbitration).
package mem_responder_pkg;

  // Transaction FSM: IDLE waits for a request, ACCESS counts wait states and
  // performs the array access, RESP holds the one-cycle ack.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Port identifiers. These double as bit indices into the one-hot grant.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Wait-state counter width; WAIT may range over 0..15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_responder_arb.sv
// mem_responder_arb: picks one of the instruction/data requests.
// MEM_RESPONDER_RR_EN defined: round-robin with a 1-bit last-grant pointer.
// MEM_RESPONDER_RR_EN undefined: fixed priority, data port wins.
module mem_responder_arb
  import mem_responder_pkg::*;
(
`ifdef MEM_RESPONDER_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_i,   // a grant is being taken this cycle
`endif
  input  logic       i_req_i,
  input  logic       d_req_i,
  output logic [1:0] gnt_o      // one-hot, indexed by PORT_I / PORT_D
);

`ifdef MEM_RESPONDER_RR_EN
  logic last_q, last_d;

  // On contention favour the port that did not win the previous grant.
  always_comb begin
    gnt_o = '0;
    if (i_req_i && d_req_i) begin
      if (last_q == PORT_I) gnt_o[PORT_D] = 1'b1;
      else                  gnt_o[PORT_I] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[PORT_D] = 1'b1;
    end else if (i_req_i) begin
      gnt_o[PORT_I] = 1'b1;
    end
  end

  // Pointer follows every grant, contended or not.
  always_comb begin
    last_d = last_q;
    if (grant_i) last_d = gnt_o[PORT_D] ? PORT_D : PORT_I;
  end

  // Reset to "instruction was last" so data wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_I;
    else        last_q <= last_d;
  end
`else
  // Data port always wins; instruction port only served when data is idle.
  always_comb begin
    gnt_o = '0;
    if (d_req_i)      gnt_o[PORT_D] = 1'b1;
    else if (i_req_i) gnt_o[PORT_I] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-port word array shared by an instruction-fetch port
// (read-only) and a data port (read/write), req/ack handshake, WAIT extra
// cycles per access. Arbitration mode selected by MEM_RESPONDER_RR_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4096,
  parameter int WAIT  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req,
  input  logic [N-1:0] i_addr,
  output logic         i_ack,
  output logic [N-1:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic         d_ack,
  output logic [N-1:0] d_rdata
);

  localparam int AW = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [N-1:0]        i_rdata_q, i_rdata_d;
  logic [N-1:0]        d_rdata_q, d_rdata_d;

  logic [1:0]          gnt;
  logic                grant;
  logic                mem_we;

  logic [N-1:0]        mem [DEPTH];

  // Address bits above the array index are ignored (addresses wrap).
  if (N > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_addr[N-1:AW], d_addr[N-1:AW]};
  end

  // A grant is taken only from IDLE; requests in ACCESS/RESP are ignored.
  assign grant = (state_q == IDLE) && (i_req || d_req);

  mem_responder_arb u_arb (
`ifdef MEM_RESPONDER_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .grant_i (grant),
`endif
    .i_req_i (i_req),
    .d_req_i (d_req),
    .gnt_o   (gnt)
  );

  // Next-state: latch the winner's fields at grant, count down wait states,
  // do the access and raise that port's ack when the counter reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          port_d  = gnt[PORT_D] ? PORT_D : PORT_I;
          addr_d  = gnt[PORT_D] ? d_addr[AW-1:0] : i_addr[AW-1:0];
          we_d    = gnt[PORT_D] & d_we;   // instruction port never writes
          wdata_d = d_wdata;
          cnt_d   = WAIT_W'(WAIT);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (we_q)                  mem_we    = 1'b1;
          else if (port_q == PORT_D) d_rdata_d = mem[addr_q];
          else                       i_rdata_d = mem[addr_q];
          if (port_q == PORT_D) d_ack_d = 1'b1;
          else                  i_ack_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // Ack is high for this cycle only; the default above clears it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, handshake and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= PORT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Array write port; contents are not reset. A reset during ACCESS drops
  // state to IDLE immediately, so the pending write never fires.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench. Expected acks (port, cycle, data) are
// queued as requests are driven and checked when acks appear. A second
// instance with WAIT=3 covers wait-state latency.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 4096;
  localparam int W0    = 0;
  localparam int W3    = 3;
`ifdef MEM_RESPONDER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic         port;
    logic         we;
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A, WAIT=0
  logic         i_req = 0, d_req = 0, d_we = 0;
  logic [N-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic         i_ack, d_ack;
  logic [N-1:0] i_rdata, d_rdata;

  // DUT B, WAIT=3 (data port only)
  logic         b_i_req = 0, b_d_req = 0, b_d_we = 0;
  logic [N-1:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0;
  logic         b_i_ack, b_d_ack;
  logic [N-1:0] b_i_rdata, b_d_rdata;

  mem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(W0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata)
  );

  mem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(W3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata)
  );

  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sb[$];
  exp_t         me;
  logic [N-1:0] model [int];
  logic [N-1:0] exp_i_rd = '0;
  logic [N-1:0] exp_d_rd = '0;
  bit           mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_rd(input logic [N-1:0] a);
    int k;
    k = int'(a) & (DEPTH - 1);
    if (model.exists(k)) return model[k];
    return '0;
  endfunction

  task automatic push_rd(input logic port, input logic [N-1:0] a, input int at);
    exp_t e;
    e.port = port; e.we = 1'b0; e.data = model_rd(a); e.cyc = at;
    sb.push_back(e);
  endtask

  // Ack monitor for DUT A: pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (i_ack && d_ack) chk("ack_overlap", 32'd1, 32'd0);
      if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
        end else begin
          me = sb.pop_front();
          chk("ack_port", {31'd0, d_ack}, {31'd0, me.port});
          chk("ack_cycle", cyc, me.cyc);
          if (!me.we) begin
            if (me.port == PORT_D) exp_d_rd = me.data;
            else                   exp_i_rd = me.data;
          end
        end
        chk("i_rdata", {16'd0, i_rdata}, {16'd0, exp_i_rd});
        chk("d_rdata", {16'd0, d_rdata}, {16'd0, exp_d_rd});
      end
    end
  end

  task automatic d_xfer(input logic we, input logic [N-1:0] a, input logic [N-1:0] wd);
    exp_t e;
    int n;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    e.port = PORT_D; e.we = we; e.cyc = cyc + 2 + W0;
    if (we) begin
      e.data = wd;
      model[int'(a) & (DEPTH - 1)] = wd;
    end else begin
      e.data = model_rd(a);
    end
    sb.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 40);
    if (!d_ack) chk("d_timeout", 32'd0, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic i_xfer(input logic [N-1:0] a);
    int n;
    @(negedge clk);
    i_req = 1'b1; i_addr = a;
    push_rd(PORT_I, a, cyc + 2 + W0);
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 40);
    if (!i_ack) chk("i_timeout", 32'd0, 32'd1);
    i_req = 1'b0;
  endtask

  task automatic b_xfer(input logic we, input logic [N-1:0] a, input logic [N-1:0] wd,
                        input logic [N-1:0] exp_rd);
    int base, n;
    @(negedge clk);
    b_d_req = 1'b1; b_d_we = we; b_d_addr = a; b_d_wdata = wd;
    base = cyc; n = 0;
    do begin
      @(negedge clk); n++;
      if (b_i_ack) chk("w3_i_ack", 32'd1, 32'd0);
    end while (!b_d_ack && n < 40);
    // grant edge E0 = base+1, ack visible after edge E0+1+WAIT
    chk("w3_latency", cyc - base, 2 + W3);
    b_d_req = 1'b0;
    chk("w3_d_rdata", {16'd0, b_d_rdata}, {16'd0, exp_rd});
    @(negedge clk);
    chk("w3_ack_width", {31'd0, b_d_ack}, 32'd0);
  endtask

  initial begin
    int base, n, cnt, acks;
    bit seen;

    // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
    #12 rst_n = 1'b0;
    #1;
    chk("rst_i_ack",   {31'd0, i_ack}, 32'd0);
    chk("rst_d_ack",   {31'd0, d_ack}, 32'd0);
    chk("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
    chk("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    chk("rst_b_d_ack", {31'd0, b_d_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (i_ack || d_ack) cnt++; end
    chk("idle_acks", cnt, 0);

    // Data write then read-back; i_rdata must stay 0.
    d_xfer(1'b1, 16'h0010, 16'hBEEF);
    d_xfer(1'b0, 16'h0010, 16'h0000);

    // Instruction fetch of 0x1010 wraps onto word 0x010.
    d_xfer(1'b1, 16'h0010, 16'hA5A5);
    i_xfer(16'h1010);

    // Simultaneous requests: data first, instruction WAIT+3 cycles later.
    @(negedge clk);
    base = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    i_req = 1'b1; i_addr = 16'h0010;
    push_rd(PORT_D, 16'h0010, base + 2 + W0);
    push_rd(PORT_I, 16'h0010, base + 2 + W0 + W0 + 3);
    n = 0; seen = 1'b0;
    do begin
      @(negedge clk); n++;
      if (d_ack) d_req = 1'b0;
      if (i_ack) begin i_req = 1'b0; seen = 1'b1; end
    end while (!seen && n < 40);
    if (!seen) chk("contend_timeout", 32'd0, 32'd1);

    // Both requests held for three grants: RR gives D,I,D; fixed gives D,D,D.
    @(negedge clk);
    base = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    i_req = 1'b1; i_addr = 16'h1010;
    for (int k = 0; k < 3; k++) begin
      if (RR && k == 1) push_rd(PORT_I, 16'h1010, base + 2 + k * (W0 + 3));
      else              push_rd(PORT_D, 16'h0010, base + 2 + k * (W0 + 3));
    end
    acks = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (i_ack || d_ack) acks++;
    end while (acks < 3 && n < 60);
    // Third ack is in RESP, so dropping both now ends the sequence cleanly.
    d_req = 1'b0; i_req = 1'b0;
    chk("held_grants", acks, 3);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a write: no ack, old contents preserved.
    d_xfer(1'b1, 16'h0020, 16'h7777);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_access_d_ack",   {31'd0, d_ack}, 32'd0);
    chk("rst_access_d_rdata", {16'd0, d_rdata}, 32'd0);
    d_req = 1'b0;
    exp_i_rd = '0; exp_d_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (i_ack || d_ack) cnt++; end
    chk("rst_access_no_ack", cnt, 0);
    d_xfer(1'b0, 16'h0020, 16'h0000);

    // WAIT=3 instance: write then read, latency 5, one-cycle ack.
    b_xfer(1'b1, 16'h0003, 16'h5A5A, 16'h0000);
    b_xfer(1'b0, 16'h0003, 16'h0000, 16'h5A5A);
    chk("w3_i_rdata", {16'd0, b_i_rdata}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
